cascade_counter: RTL and testbench

Parametrised two-stage counter: a primary counter steps up or down on `en`, and a secondary counter decrements once each time the primary passes a runtime compare value. It replaces the fixed 4-bit up/down pair in the timing and test-pattern path, adding width and compare generalisation, direction control, parallel load, wrap/saturate mode and event pulses for downstream sequencing logic.

---
 rtl/cascade_counter.sv | 71 +++++++
 tb/tb_cascade_counter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cascade_counter.sv
// Two-stage counter: a primary up/down counter with parallel load, and a secondary
// down-counter that decrements each time a stepping primary passes cmp_val.
module cascade_counter #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] SEC_INIT = '1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] pri_cnt,
    output logic [WIDTH-1:0] sec_cnt,
    output logic             pri_wrap,
    output logic             match_pulse,
    output logic             sec_zero
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] pri_step;
    logic [WIDTH-1:0] sec_dec;
    logic             wrap_evt;
    logic             match_evt;

    always_comb begin
        pri_step  = pri_cnt + ONE;
        wrap_evt  = (pri_cnt == ALL_ONES);
        if (dir) begin
            pri_step = pri_cnt - ONE;
            wrap_evt = (pri_cnt == ZERO);
        end
        // Compare uses the pre-step value, so the match shows one count past cmp_val.
        match_evt = (pri_cnt == cmp_val);
        sec_dec   = sec_cnt - ONE;
        if (sec_cnt == ZERO) begin
            sec_dec = SATURATE ? ZERO : ALL_ONES;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pri_cnt     <= ZERO;
            sec_cnt     <= SEC_INIT;
            pri_wrap    <= 1'b0;
            match_pulse <= 1'b0;
        end else if (load) begin
            pri_cnt     <= load_val;
            pri_wrap    <= 1'b0;
            match_pulse <= 1'b0;
        end else if (en) begin
            pri_cnt     <= pri_step;
            pri_wrap    <= wrap_evt;
            match_pulse <= match_evt;
            if (match_evt) begin
                sec_cnt <= sec_dec;
            end
        end else begin
            pri_wrap    <= 1'b0;
            match_pulse <= 1'b0;
        end
    end

    assign sec_zero = (sec_cnt == ZERO);

endmodule

// File: tb/tb_cascade_counter.sv
// Scoreboard bench for cascade_counter: two configurations (4-bit wrapping, 8-bit
// saturating) share one stimulus stream and are checked against an arithmetic model.
module tb_cascade_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic [7:0] cmp_val = '0;

    logic [3:0] a_pri, a_sec;
    logic       a_wrap, a_match, a_zero;
    logic [7:0] b_pri, b_sec;
    logic       b_wrap, b_match, b_zero;

    always #5 clk = ~clk;

    cascade_counter #(.WIDTH(4), .SEC_INIT(4'd15), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_val(load_val[3:0]), .cmp_val(cmp_val[3:0]),
        .pri_cnt(a_pri), .sec_cnt(a_sec), .pri_wrap(a_wrap),
        .match_pulse(a_match), .sec_zero(a_zero)
    );

    cascade_counter #(.WIDTH(8), .SEC_INIT(8'd2), .SATURATE(1'b1)) u_b (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .cmp_val(cmp_val),
        .pri_cnt(b_pri), .sec_cnt(b_sec), .pri_wrap(b_wrap),
        .match_pulse(b_match), .sec_zero(b_zero)
    );

    typedef struct {
        int pri;
        int sec;
        int wrap;
        int match;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks = 0;
    int errors = 0;

    // Reference state per configuration: index 0 = 4-bit wrap, 1 = 8-bit saturate.
    int m_pri[2];
    int m_sec[2];
    int m_mod[2]  = '{16, 256};
    int m_init[2] = '{15, 2};
    int m_sat[2]  = '{0, 1};

    function automatic exp_t model_next(input int k, input int r, input int ld,
                                        input int e, input int d, input int lv, input int cv);
        exp_t x;
        int   mod;
        mod     = m_mod[k];
        x.wrap  = 0;
        x.match = 0;
        if (r != 0) begin
            m_pri[k] = 0;
            m_sec[k] = m_init[k];
        end else if (ld != 0) begin
            m_pri[k] = lv % mod;
        end else if (e != 0) begin
            if (m_pri[k] == cv % mod) begin
                x.match = 1;
                if (m_sec[k] > 0) m_sec[k] = m_sec[k] - 1;
                else if (m_sat[k] == 0) m_sec[k] = mod - 1;
            end
            if (d == 0) begin
                if (m_pri[k] == mod - 1) x.wrap = 1;
                m_pri[k] = (m_pri[k] + 1) % mod;
            end else begin
                if (m_pri[k] == 0) x.wrap = 1;
                m_pri[k] = (m_pri[k] + mod - 1) % mod;
            end
        end
        x.pri = m_pri[k];
        x.sec = m_sec[k];
        return x;
    endfunction

    task automatic drive(input int r, input int ld, input int e, input int d,
                         input int lv, input int cv);
        rst      = (r != 0);
        load     = (ld != 0);
        en       = (e != 0);
        dir      = (d != 0);
        load_val = 8'(lv);
        cmp_val  = 8'(cv);
        q_a.push_back(model_next(0, r, ld, e, d, lv, cv));
        q_b.push_back(model_next(1, r, ld, e, d, lv, cv));
        @(negedge clk);
    endtask

    function automatic void chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (q_a.size() > 0) begin
            exp_t ea;
            exp_t eb;
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            chk("a_pri_cnt",     int'(a_pri),   ea.pri);
            chk("a_sec_cnt",     int'(a_sec),   ea.sec);
            chk("a_pri_wrap",    int'(a_wrap),  ea.wrap);
            chk("a_match_pulse", int'(a_match), ea.match);
            chk("a_sec_zero",    int'(a_zero),  int'(ea.sec == 0));
            chk("b_pri_cnt",     int'(b_pri),   eb.pri);
            chk("b_sec_cnt",     int'(b_sec),   eb.sec);
            chk("b_pri_wrap",    int'(b_wrap),  eb.wrap);
            chk("b_match_pulse", int'(b_match), eb.match);
            chk("b_sec_zero",    int'(b_zero),  int'(eb.sec == 0));
        end
    end

    initial begin
        int cv;
        int drain;
        m_pri = '{0, 0};
        m_sec = '{15, 2};

        // Up count from reset, cmp 12.
        drive(1, 0, 0, 0, 0, 12);
        drive(1, 0, 0, 0, 0, 12);
        for (int i = 0; i < 20; i++) drive(0, 0, 1, 0, 0, 12);

        // Down count from reset, cmp 3.
        drive(1, 0, 0, 1, 0, 3);
        for (int i = 0; i < 20; i++) drive(0, 0, 1, 1, 0, 3);

        // Load with en high, hold at cmp, then resume.
        drive(0, 1, 1, 0, 11, 11);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 11);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 11);

        // Reset on the same edge as a pending match.
        drive(0, 1, 0, 0, 12, 12);
        drive(1, 0, 1, 0, 0, 12);
        drive(0, 0, 0, 0, 0, 12);

        // Long run at cmp 0: secondary wraps (4-bit) and saturates (8-bit).
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) drive(0, 0, 1, 0, 0, 0);

        // Randomised mix.
        cv = 0;
        for (int i = 0; i < 10000; i++) begin
            int r, ld, e, d;
            if ($urandom_range(0, 49) == 0) cv = int'($urandom_range(0, 255));
            r  = ($urandom_range(0, 199) == 0) ? 1 : 0;
            ld = ($urandom_range(0, 29) == 0) ? 1 : 0;
            e  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            d  = ($urandom_range(0, 15) == 0) ? 1 - int'(dir) : int'(dir);
            drive(r, ld, e, d, int'($urandom_range(0, 255)), cv);
        end

        drain = 0;
        while (q_a.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        if (q_a.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_a.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
